// File: rtl/tlb_unit_pkg.sv
// Shared definitions for the joint TLB: CP0 register field positions,
// array geometry and the stored entry layout.
package tlb_unit_pkg;

  localparam int TLB_ENTRIES = 32;
  localparam int TLB_IDXBITS = 5;

  localparam int ENTRYLO_PFN_HI = 25;
  localparam int ENTRYLO_PFN_LO = 6;
  localparam int ENTRYLO_C_HI   = 5;
  localparam int ENTRYLO_C_LO   = 3;
  localparam int ENTRYLO_D      = 2;
  localparam int ENTRYLO_V      = 1;
  localparam int ENTRYLO_G      = 0;

  localparam int ENTRYHI_VPN2_HI = 31;
  localparam int ENTRYHI_VPN2_LO = 13;
  localparam int ENTRYHI_ASID_HI = 7;
  localparam int ENTRYHI_ASID_LO = 0;

  localparam int PAGEMASK_MASK_HI = 24;
  localparam int PAGEMASK_MASK_LO = 13;
  localparam int PAGEMASK_MASK_W  = PAGEMASK_MASK_HI - PAGEMASK_MASK_LO + 1;

  localparam int INDEX_P        = 31;
  localparam int INDEX_INDEX_HI = TLB_IDXBITS - 1;
  localparam int INDEX_INDEX_LO = 0;

  // One half (even or odd page) of an entry.
  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_half_t;

  // The fields the match logic needs.
  typedef struct packed {
    logic [18:0]                vpn2;
    logic [7:0]                 asid;
    logic                       g;
    logic [PAGEMASK_MASK_W-1:0] mask;
  } tlb_tag_t;

  typedef struct packed {
    tlb_tag_t  tag;
    tlb_half_t even;
    tlb_half_t odd;
  } tlb_entry_t;

  // Pull the page half out of an EntryLo register image.
  function automatic tlb_half_t unpack_lo(input logic [31:0] lo);
    tlb_half_t h;
    h.pfn = lo[ENTRYLO_PFN_HI:ENTRYLO_PFN_LO];
    h.c   = lo[ENTRYLO_C_HI:ENTRYLO_C_LO];
    h.d   = lo[ENTRYLO_D];
    h.v   = lo[ENTRYLO_V];
    return h;
  endfunction

  // Rebuild an EntryLo register image from a stored half and the shared G.
  function automatic logic [31:0] pack_lo(input tlb_half_t h, input logic g);
    return {6'd0, h.pfn, h.c, h.d, h.v, g};
  endfunction

endpackage

// File: rtl/tlb_match.sv
// Parallel tag compare against every entry followed by a lowest-index
// priority encoder. Used both for TLBP and for the translation port.
module tlb_match
  import tlb_unit_pkg::*;
(
  input  logic [TLB_ENTRIES-1:0]           present,
  input  tlb_tag_t [TLB_ENTRIES-1:0]       tags,
  input  logic [18:0]                      vpn2,
  input  logic [7:0]                       asid,
  output logic                             hit,
  output logic [TLB_IDXBITS-1:0]           index
);

  logic [TLB_ENTRIES-1:0] hit_vec;

  // Per-entry match: present, VPN2 equal outside the page mask, global or same ASID.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      hit_vec[i] = present[i]
                   && (((tags[i].vpn2 ^ vpn2) & ~{7'd0, tags[i].mask}) == 19'd0)
                   && (tags[i].g || (tags[i].asid == asid));
    end
  end

  // Lowest matching index wins when several entries overlap.
  always_comb begin
    hit   = |hit_vec;
    index = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) index = TLB_IDXBITS'(i);
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// Joint TLB: executes the CP0 TLB instructions and serves one registered
// virtual-to-physical lookup port.
module tlb_unit
  import tlb_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] cp0_entryhi,
  input  logic [31:0] cp0_entrylo0,
  input  logic [31:0] cp0_entrylo1,
  input  logic [11:0] cp0_mask,
  input  logic [31:0] cp0_index,
  input  logic [31:0] cp0_random,
  input  logic        op_tlbwi,
  input  logic        op_tlbwr,
  input  logic        op_tlbr,
  input  logic        op_tlbp,
  output logic        tlbr_done,
  output logic [31:0] tlbr_lo0,
  output logic [31:0] tlbr_lo1,
  output logic [31:0] tlbr_hi,
  output logic [11:0] tlbr_mask,
  output logic        tlbp_done,
  output logic [31:0] tlbp_index,
  input  logic        lk_req,
  input  logic [31:0] lk_vaddr,
  output logic        lk_valid,
  output logic        lk_miss,
  output logic        lk_v,
  output logic        lk_d,
  output logic [2:0]  lk_c,
  output logic [31:0] lk_paddr
);

  tlb_entry_t [TLB_ENTRIES-1:0] entries_q, entries_d;
  logic [TLB_ENTRIES-1:0]       present_q, present_d;
  tlb_tag_t [TLB_ENTRIES-1:0]   tags;

  logic                   wr_en, do_tlbr, do_tlbp;
  logic [TLB_IDXBITS-1:0] wr_idx, rd_idx;
  tlb_entry_t             new_entry, rd_ent, lk_ent;

  logic                   probe_hit, lk_hit;
  logic [TLB_IDXBITS-1:0] probe_idx, lk_idx;
  logic                   lk_sel_odd;
  tlb_half_t              lk_half;
  logic [31:0]            lk_offmask;

  logic        tlbr_done_q, tlbr_done_d;
  logic [31:0] tlbr_lo0_q, tlbr_lo0_d, tlbr_lo1_q, tlbr_lo1_d, tlbr_hi_q, tlbr_hi_d;
  logic [11:0] tlbr_mask_q, tlbr_mask_d;
  logic        tlbp_done_q, tlbp_done_d;
  logic [31:0] tlbp_index_q, tlbp_index_d;
  logic        lk_valid_q, lk_valid_d, lk_miss_q, lk_miss_d;
  logic        lk_v_q, lk_v_d, lk_d_q, lk_d_d;
  logic [2:0]  lk_c_q, lk_c_d;
  logic [31:0] lk_paddr_q, lk_paddr_d;

  logic unused_bits;
  assign unused_bits = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26],
                         cp0_index[31:TLB_IDXBITS], cp0_random[31:TLB_IDXBITS]};

  // Only the highest-priority command executes: tlbwi > tlbwr > tlbr > tlbp.
  assign wr_en   = op_tlbwi | op_tlbwr;
  assign wr_idx  = op_tlbwi ? cp0_index[INDEX_INDEX_HI:INDEX_INDEX_LO]
                            : cp0_random[INDEX_INDEX_HI:INDEX_INDEX_LO];
  assign do_tlbr = ~wr_en & op_tlbr;
  assign do_tlbp = ~wr_en & ~op_tlbr & op_tlbp;
  assign rd_idx  = cp0_index[INDEX_INDEX_HI:INDEX_INDEX_LO];

  // Assemble the entry image to be written from the CP0 registers.
  always_comb begin
    new_entry          = '0;
    new_entry.tag.vpn2 = cp0_entryhi[ENTRYHI_VPN2_HI:ENTRYHI_VPN2_LO];
    new_entry.tag.asid = cp0_entryhi[ENTRYHI_ASID_HI:ENTRYHI_ASID_LO];
    new_entry.tag.g    = cp0_entrylo0[ENTRYLO_G] & cp0_entrylo1[ENTRYLO_G];
    new_entry.tag.mask = cp0_mask;
    new_entry.even     = unpack_lo(cp0_entrylo0);
    new_entry.odd      = unpack_lo(cp0_entrylo1);
  end

  // Array update; lookups and probes in this cycle still see the old contents.
  always_comb begin
    entries_d = entries_q;
    present_d = present_q;
    if (wr_en) begin
      entries_d[wr_idx] = new_entry;
      present_d[wr_idx] = 1'b1;
    end
  end

  // Tag view of the array for the two match engines.
  always_comb begin
    tags = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) tags[i] = entries_q[i].tag;
  end

  tlb_match u_probe_match (
    .present (present_q),
    .tags    (tags),
    .vpn2    (cp0_entryhi[ENTRYHI_VPN2_HI:ENTRYHI_VPN2_LO]),
    .asid    (cp0_entryhi[ENTRYHI_ASID_HI:ENTRYHI_ASID_LO]),
    .hit     (probe_hit),
    .index   (probe_idx)
  );

  tlb_match u_lookup_match (
    .present (present_q),
    .tags    (tags),
    .vpn2    (lk_vaddr[31:13]),
    .asid    (cp0_entryhi[ENTRYHI_ASID_HI:ENTRYHI_ASID_LO]),
    .hit     (lk_hit),
    .index   (lk_idx)
  );

  assign rd_ent = entries_q[rd_idx];
  assign lk_ent = entries_q[lk_idx];

  // Page-size dependent half select and offset merge; mask+1 is one-hot at the select bit.
  always_comb begin
    lk_sel_odd = |(lk_vaddr[24:12] & ({1'b0, lk_ent.tag.mask} + 13'd1));
    lk_half    = lk_sel_odd ? lk_ent.odd : lk_ent.even;
    lk_offmask = {8'd0, lk_ent.tag.mask, 12'hFFF};
  end

  // Next values of the registered read, probe and lookup results.
  always_comb begin
    tlbr_done_d  = 1'b0;
    tlbr_lo0_d   = tlbr_lo0_q;
    tlbr_lo1_d   = tlbr_lo1_q;
    tlbr_hi_d    = tlbr_hi_q;
    tlbr_mask_d  = tlbr_mask_q;
    tlbp_done_d  = 1'b0;
    tlbp_index_d = tlbp_index_q;
    lk_valid_d   = 1'b0;
    lk_miss_d    = lk_miss_q;
    lk_v_d       = lk_v_q;
    lk_d_d       = lk_d_q;
    lk_c_d       = lk_c_q;
    lk_paddr_d   = lk_paddr_q;
    if (do_tlbr) begin
      tlbr_done_d = 1'b1;
      if (present_q[rd_idx]) begin
        tlbr_lo0_d  = pack_lo(rd_ent.even, rd_ent.tag.g);
        tlbr_lo1_d  = pack_lo(rd_ent.odd, rd_ent.tag.g);
        tlbr_hi_d   = {rd_ent.tag.vpn2, 5'd0, rd_ent.tag.asid};
        tlbr_mask_d = rd_ent.tag.mask;
      end else begin
        tlbr_lo0_d  = '0;
        tlbr_lo1_d  = '0;
        tlbr_hi_d   = '0;
        tlbr_mask_d = '0;
      end
    end
    if (do_tlbp) begin
      tlbp_done_d                                = 1'b1;
      tlbp_index_d                               = '0;
      tlbp_index_d[INDEX_P]                      = ~probe_hit;
      tlbp_index_d[INDEX_INDEX_HI:INDEX_INDEX_LO] = probe_hit ? probe_idx : '0;
    end
    if (lk_req) begin
      lk_valid_d = 1'b1;
      lk_miss_d  = ~lk_hit;
      if (lk_hit) begin
        lk_v_d     = lk_half.v;
        lk_d_d     = lk_half.d;
        lk_c_d     = lk_half.c;
        lk_paddr_d = ({lk_half.pfn, 12'd0} & ~lk_offmask) | (lk_vaddr & lk_offmask);
      end else begin
        lk_v_d     = 1'b0;
        lk_d_d     = 1'b0;
        lk_c_d     = 3'd0;
        lk_paddr_d = '0;
      end
    end
  end

  // Entry payload is not reset; the present bits alone make the array empty.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  // Present bits and all result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      present_q    <= '0;
      tlbr_done_q  <= 1'b0;
      tlbr_lo0_q   <= '0;
      tlbr_lo1_q   <= '0;
      tlbr_hi_q    <= '0;
      tlbr_mask_q  <= '0;
      tlbp_done_q  <= 1'b0;
      tlbp_index_q <= '0;
      lk_valid_q   <= 1'b0;
      lk_miss_q    <= 1'b0;
      lk_v_q       <= 1'b0;
      lk_d_q       <= 1'b0;
      lk_c_q       <= '0;
      lk_paddr_q   <= '0;
    end else begin
      present_q    <= present_d;
      tlbr_done_q  <= tlbr_done_d;
      tlbr_lo0_q   <= tlbr_lo0_d;
      tlbr_lo1_q   <= tlbr_lo1_d;
      tlbr_hi_q    <= tlbr_hi_d;
      tlbr_mask_q  <= tlbr_mask_d;
      tlbp_done_q  <= tlbp_done_d;
      tlbp_index_q <= tlbp_index_d;
      lk_valid_q   <= lk_valid_d;
      lk_miss_q    <= lk_miss_d;
      lk_v_q       <= lk_v_d;
      lk_d_q       <= lk_d_d;
      lk_c_q       <= lk_c_d;
      lk_paddr_q   <= lk_paddr_d;
    end
  end

  assign tlbr_done  = tlbr_done_q;
  assign tlbr_lo0   = tlbr_lo0_q;
  assign tlbr_lo1   = tlbr_lo1_q;
  assign tlbr_hi    = tlbr_hi_q;
  assign tlbr_mask  = tlbr_mask_q;
  assign tlbp_done  = tlbp_done_q;
  assign tlbp_index = tlbp_index_q;
  assign lk_valid   = lk_valid_q;
  assign lk_miss    = lk_miss_q;
  assign lk_v       = lk_v_q;
  assign lk_d       = lk_d_q;
  assign lk_c       = lk_c_q;
  assign lk_paddr   = lk_paddr_q;

endmodule

// File: tb/tb_tlb_unit.sv
// Directed bench for tlb_unit: CP0 TLB commands, translation port,
// priority, hazards and reset behaviour.
module tb_tlb_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] cp0_entryhi = '0, cp0_entrylo0 = '0, cp0_entrylo1 = '0;
  logic [11:0] cp0_mask = '0;
  logic [31:0] cp0_index = '0, cp0_random = '0;
  logic        op_tlbwi = 1'b0, op_tlbwr = 1'b0, op_tlbr = 1'b0, op_tlbp = 1'b0;
  logic        tlbr_done, tlbp_done;
  logic [31:0] tlbr_lo0, tlbr_lo1, tlbr_hi, tlbp_index;
  logic [11:0] tlbr_mask;
  logic        lk_req = 1'b0;
  logic [31:0] lk_vaddr = '0;
  logic        lk_valid, lk_miss, lk_v, lk_d;
  logic [2:0]  lk_c;
  logic [31:0] lk_paddr;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tlb_unit dut (
    .clk(clk), .resetn(resetn),
    .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .cp0_mask(cp0_mask), .cp0_index(cp0_index), .cp0_random(cp0_random),
    .op_tlbwi(op_tlbwi), .op_tlbwr(op_tlbwr), .op_tlbr(op_tlbr), .op_tlbp(op_tlbp),
    .tlbr_done(tlbr_done), .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1), .tlbr_hi(tlbr_hi),
    .tlbr_mask(tlbr_mask), .tlbp_done(tlbp_done), .tlbp_index(tlbp_index),
    .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_valid(lk_valid), .lk_miss(lk_miss),
    .lk_v(lk_v), .lk_d(lk_d), .lk_c(lk_c), .lk_paddr(lk_paddr)
  );

  // Advance one clock and land just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic use_wr, input logic [4:0] idx, input logic [31:0] hi,
                             input logic [31:0] lo0, input logic [31:0] lo1, input logic [11:0] mask);
    cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1; cp0_mask = mask;
    if (use_wr) begin cp0_random = {27'd0, idx}; op_tlbwr = 1'b1; end
    else begin cp0_index = {27'd0, idx}; op_tlbwi = 1'b1; end
    tick();
    op_tlbwi = 1'b0; op_tlbwr = 1'b0;
  endtask

  task automatic read_entry(input logic [4:0] idx);
    cp0_index = {27'd0, idx}; op_tlbr = 1'b1;
    tick();
    op_tlbr = 1'b0;
  endtask

  task automatic probe(input logic [31:0] hi);
    cp0_entryhi = hi; op_tlbp = 1'b1;
    tick();
    op_tlbp = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] va, input logic [7:0] asid);
    cp0_entryhi = {cp0_entryhi[31:8], asid}; lk_vaddr = va; lk_req = 1'b1;
    tick();
    lk_req = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    n_checks++; if (tlbr_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_tlbr_done got=%b exp=0", tlbr_done); end
    n_checks++; if (tlbp_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_tlbp_done got=%b exp=0", tlbp_done); end
    n_checks++; if (lk_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_lk_valid got=%b exp=0", lk_valid); end
    n_checks++; if (tlbp_index !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_tlbp_index got=%h exp=0", tlbp_index); end
    n_checks++; if (lk_paddr !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_lk_paddr got=%h exp=0", lk_paddr); end
    resetn = 1'b1;
    read_entry(5'd7);
    n_checks++; if (tlbr_done !== 1'b1) begin n_fail++; $display("[TB] FAIL empty_tlbr_done got=%b exp=1", tlbr_done); end
    n_checks++; if ({tlbr_hi, tlbr_lo0, tlbr_lo1} !== 96'h0) begin n_fail++; $display("[TB] FAIL empty_tlbr_data got=%h exp=0", {tlbr_hi, tlbr_lo0, tlbr_lo1}); end
    n_checks++; if (tlbr_mask !== 12'h0) begin n_fail++; $display("[TB] FAIL empty_tlbr_mask got=%h exp=0", tlbr_mask); end
    lookup(32'h00402ABC, 8'h11);
    n_checks++; if ({lk_valid, lk_miss} !== 2'b11) begin n_fail++; $display("[TB] FAIL empty_lookup valid_miss got=%b exp=11", {lk_valid, lk_miss}); end
  endtask

  task automatic test_tlbwi_tlbr();
    write_entry(1'b0, 5'd5, 32'h00402011, 32'h0000105F, 32'h0000109F, 12'h000);
    read_entry(5'd5);
    n_checks++; if (tlbr_done !== 1'b1) begin n_fail++; $display("[TB] FAIL wi_r_done got=%b exp=1", tlbr_done); end
    n_checks++; if (tlbr_hi !== 32'h00402011) begin n_fail++; $display("[TB] FAIL wi_r_hi got=%h exp=00402011", tlbr_hi); end
    n_checks++; if (tlbr_lo0 !== 32'h0000105F) begin n_fail++; $display("[TB] FAIL wi_r_lo0 got=%h exp=0000105f", tlbr_lo0); end
    n_checks++; if (tlbr_lo1 !== 32'h0000109F) begin n_fail++; $display("[TB] FAIL wi_r_lo1 got=%h exp=0000109f", tlbr_lo1); end
    tick();
    n_checks++; if (tlbr_done !== 1'b0) begin n_fail++; $display("[TB] FAIL wi_r_done_pulse got=%b exp=0", tlbr_done); end
  endtask

  task automatic test_tlbp();
    probe(32'h00402011);
    n_checks++; if (tlbp_done !== 1'b1) begin n_fail++; $display("[TB] FAIL p_hit_done got=%b exp=1", tlbp_done); end
    n_checks++; if (tlbp_index !== 32'h00000005) begin n_fail++; $display("[TB] FAIL p_hit_index got=%h exp=00000005", tlbp_index); end
    probe(32'h00404011);
    n_checks++; if (tlbp_index !== 32'h80000000) begin n_fail++; $display("[TB] FAIL p_miss_index got=%h exp=80000000", tlbp_index); end
    write_entry(1'b0, 5'd9, 32'h00402011, 32'h0000105F, 32'h0000109F, 12'h000);
    probe(32'h00402011);
    n_checks++; if (tlbp_index !== 32'h00000005) begin n_fail++; $display("[TB] FAIL p_dup_index got=%h exp=00000005", tlbp_index); end
    tick();
    n_checks++; if (tlbp_done !== 1'b0) begin n_fail++; $display("[TB] FAIL p_done_pulse got=%b exp=0", tlbp_done); end
  endtask

  task automatic test_lookup_4k();
    lookup(32'h00402ABC, 8'h11);
    n_checks++; if ({lk_valid, lk_miss, lk_v, lk_d, lk_c} !== 7'b1011011) begin n_fail++; $display("[TB] FAIL lk_even_flags got=%b exp=1011011", {lk_valid, lk_miss, lk_v, lk_d, lk_c}); end
    n_checks++; if (lk_paddr !== 32'h00041ABC) begin n_fail++; $display("[TB] FAIL lk_even_paddr got=%h exp=00041abc", lk_paddr); end
    lookup(32'h00403ABC, 8'h11);
    n_checks++; if (lk_paddr !== 32'h00042ABC) begin n_fail++; $display("[TB] FAIL lk_odd_paddr got=%h exp=00042abc", lk_paddr); end
    write_entry(1'b0, 5'd12, 32'h00602011, 32'h0000105E, 32'h0000109E, 12'h000);
    lookup(32'h00602ABC, 8'h12);
    n_checks++; if ({lk_valid, lk_miss, lk_v, lk_d, lk_c} !== 7'b1100000) begin n_fail++; $display("[TB] FAIL lk_asid_miss_flags got=%b exp=1100000", {lk_valid, lk_miss, lk_v, lk_d, lk_c}); end
    n_checks++; if (lk_paddr !== 32'h0) begin n_fail++; $display("[TB] FAIL lk_asid_miss_paddr got=%h exp=0", lk_paddr); end
    lookup(32'h00602ABC, 8'h11);
    n_checks++; if ({lk_miss, lk_paddr} !== {1'b0, 32'h00041ABC}) begin n_fail++; $display("[TB] FAIL lk_asid_hit got=%b/%h exp=0/00041abc", lk_miss, lk_paddr); end
  endtask

  task automatic test_back_to_back();
    cp0_entryhi = {cp0_entryhi[31:8], 8'h11};
    lk_req = 1'b1; lk_vaddr = 32'h00402123;
    tick();
    n_checks++; if ({lk_valid, lk_paddr} !== {1'b1, 32'h00041123}) begin n_fail++; $display("[TB] FAIL b2b_first got=%b/%h exp=1/00041123", lk_valid, lk_paddr); end
    lk_vaddr = 32'h00403456;
    tick();
    n_checks++; if ({lk_valid, lk_paddr} !== {1'b1, 32'h00042456}) begin n_fail++; $display("[TB] FAIL b2b_second got=%b/%h exp=1/00042456", lk_valid, lk_paddr); end
    lk_req = 1'b0;
    tick();
    n_checks++; if (lk_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_idle_valid got=%b exp=0", lk_valid); end
  endtask

  task automatic test_large_page();
    write_entry(1'b0, 5'd20, 32'h00400000, 32'h0000401F, 32'h0000801F, 12'h003);
    lookup(32'h00401234, 8'h55);
    n_checks++; if ({lk_miss, lk_paddr} !== {1'b0, 32'h00101234}) begin n_fail++; $display("[TB] FAIL lp_even got=%b/%h exp=0/00101234", lk_miss, lk_paddr); end
    lookup(32'h00405234, 8'h99);
    n_checks++; if ({lk_miss, lk_paddr} !== {1'b0, 32'h00201234}) begin n_fail++; $display("[TB] FAIL lp_odd got=%b/%h exp=0/00201234", lk_miss, lk_paddr); end
    read_entry(5'd20);
    n_checks++; if (tlbr_mask !== 12'h003) begin n_fail++; $display("[TB] FAIL lp_tlbr_mask got=%h exp=003", tlbr_mask); end
  endtask

  task automatic test_tlbwr();
    cp0_index = 32'd0;
    write_entry(1'b1, 5'd31, 32'h12346033, 32'h02ABCDE7, 32'h01234566, 12'h000);
    read_entry(5'd31);
    n_checks++; if (tlbr_hi !== 32'h12346033) begin n_fail++; $display("[TB] FAIL wr_hi got=%h exp=12346033", tlbr_hi); end
    n_checks++; if (tlbr_lo0 !== 32'h02ABCDE6) begin n_fail++; $display("[TB] FAIL wr_lo0 got=%h exp=02abcde6", tlbr_lo0); end
    n_checks++; if (tlbr_lo1 !== 32'h01234566) begin n_fail++; $display("[TB] FAIL wr_lo1 got=%h exp=01234566", tlbr_lo1); end
    read_entry(5'd0);
    n_checks++; if (tlbr_hi !== 32'h0) begin n_fail++; $display("[TB] FAIL wr_index0_untouched got=%h exp=0", tlbr_hi); end
  endtask

  task automatic test_priority();
    cp0_index = 32'd7; cp0_entryhi = 32'h00802011; cp0_entrylo0 = 32'h0000105F; cp0_entrylo1 = 32'h0000109F; cp0_mask = 12'h000;
    op_tlbwi = 1'b1; op_tlbp = 1'b1;
    tick();
    op_tlbwi = 1'b0; op_tlbp = 1'b0;
    n_checks++; if (tlbp_done !== 1'b0) begin n_fail++; $display("[TB] FAIL pri_wi_over_p got=%b exp=0", tlbp_done); end
    read_entry(5'd7);
    n_checks++; if (tlbr_hi !== 32'h00802011) begin n_fail++; $display("[TB] FAIL pri_wi_written got=%h exp=00802011", tlbr_hi); end
    cp0_index = 32'd5; op_tlbr = 1'b1; op_tlbp = 1'b1;
    tick();
    op_tlbr = 1'b0; op_tlbp = 1'b0;
    n_checks++; if ({tlbr_done, tlbp_done} !== 2'b10) begin n_fail++; $display("[TB] FAIL pri_r_over_p got=%b exp=10", {tlbr_done, tlbp_done}); end
    n_checks++; if (tlbr_hi !== 32'h00402011) begin n_fail++; $display("[TB] FAIL pri_r_hi got=%h exp=00402011", tlbr_hi); end
    cp0_index = 32'd8; cp0_random = 32'd10; cp0_entryhi = 32'h00A02011;
    op_tlbwi = 1'b1; op_tlbwr = 1'b1;
    tick();
    op_tlbwi = 1'b0; op_tlbwr = 1'b0;
    read_entry(5'd10);
    n_checks++; if (tlbr_hi !== 32'h0) begin n_fail++; $display("[TB] FAIL pri_wr_suppressed got=%h exp=0", tlbr_hi); end
    read_entry(5'd8);
    n_checks++; if (tlbr_hi !== 32'h00A02011) begin n_fail++; $display("[TB] FAIL pri_wi_over_wr got=%h exp=00a02011", tlbr_hi); end
  endtask

  task automatic test_reset_midop();
    cp0_entryhi = 32'h00402011; op_tlbp = 1'b1; lk_req = 1'b1; lk_vaddr = 32'h00402ABC;
    resetn = 1'b0;
    tick();
    op_tlbp = 1'b0; lk_req = 1'b0;
    n_checks++; if ({tlbp_done, lk_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL midop_no_pulse got=%b exp=00", {tlbp_done, lk_valid}); end
    tick();
    n_checks++; if ({tlbp_done, lk_valid} !== 2'b00) begin n_fail++; $display("[TB] FAIL midop_still_quiet got=%b exp=00", {tlbp_done, lk_valid}); end
    resetn = 1'b1;
    lookup(32'h00402ABC, 8'h11);
    n_checks++; if ({lk_valid, lk_miss} !== 2'b11) begin n_fail++; $display("[TB] FAIL midop_cleared got=%b exp=11", {lk_valid, lk_miss}); end
  endtask

  task automatic test_same_cycle_write_lookup();
    cp0_index = 32'd3; cp0_entryhi = 32'h00402011; cp0_entrylo0 = 32'h0000105F; cp0_entrylo1 = 32'h0000109F; cp0_mask = 12'h000;
    op_tlbwi = 1'b1; lk_req = 1'b1; lk_vaddr = 32'h00402ABC;
    tick();
    op_tlbwi = 1'b0;
    n_checks++; if ({lk_valid, lk_miss} !== 2'b11) begin n_fail++; $display("[TB] FAIL same_cycle_old got=%b exp=11", {lk_valid, lk_miss}); end
    tick();
    lk_req = 1'b0;
    n_checks++; if ({lk_valid, lk_miss, lk_paddr} !== {2'b10, 32'h00041ABC}) begin n_fail++; $display("[TB] FAIL next_cycle_new got=%b%b/%h exp=10/00041abc", lk_valid, lk_miss, lk_paddr); end
  endtask

  initial begin
    $display("[TB] starting tlb_unit directed tests");
    test_reset();
    test_tlbwi_tlbr();
    test_tlbp();
    test_lookup_4k();
    test_back_to_back();
    test_large_page();
    test_tlbwr();
    test_priority();
    test_reset_midop();
    test_same_cycle_write_lookup();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
